enable_delay_line: RTL and testbench

Parametrised successor to the single enabled D flip-flop. It is a WIDTH-bit, DEPTH-stage delay line in which every stage shares one load enable, and each word carries a valid bit. It adds a synchronous flush, an occupancy counter and a full flag. It sits between a producer and a consumer that need a fixed, stallable latency of DEPTH enabled cycles.

---
 rtl/enable_delay_line.sv | 79 +++++++
 tb/tb_enable_delay_line.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/enable_delay_line.sv
// WIDTH-bit, DEPTH-stage delay line with a shared load enable, per-word valid bits, sync flush and occupancy tracking.
// Optional ENABLE_DELAY_LINE_TAPS_EN exposes every stage on the taps port.
module enable_delay_line #(
  parameter int                WIDTH   = 8,
  parameter int                DEPTH   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               d,
  input  logic                           d_valid,
  output logic [WIDTH-1:0]               q,
  output logic                           q_valid,
  output logic [$clog2(DEPTH+1)-1:0]     fill,
  output logic                           full
`ifdef ENABLE_DELAY_LINE_TAPS_EN
  ,
  output logic [WIDTH*DEPTH-1:0]         taps
`endif
);

  localparam int             FW       = $clog2(DEPTH+1);
  localparam logic [FW-1:0]  FULL_CNT = FW'(DEPTH);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] v;
  logic [FW-1:0]    fill_r;

  // One word in and one out cancel; the counter can never leave 0..DEPTH
  // because v[DEPTH-1] is only set when a word is actually held.
  function automatic logic [FW-1:0] fill_upd(input logic [FW-1:0] f,
                                             input logic          word_in,
                                             input logic          word_out);
    logic [FW-1:0] r;
    r = f;
    case ({word_in, word_out})
      2'b10:   r = f + FW'(1);
      2'b01:   r = f - FW'(1);
      default: r = f;
    endcase
    return r;
  endfunction

  // Shift stage: flush beats enable, enable beats hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      v      <= '0;
      fill_r <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      v      <= '0;
      fill_r <= '0;
    end else if (enable) begin
      stage[0] <= d;
      v[0]     <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
        v[i]     <= v[i-1];
      end
      fill_r <= fill_upd(fill_r, d_valid, v[DEPTH-1]);
    end
  end

  // Output stage: everything but full comes straight from flops
  assign q       = stage[DEPTH-1];
  assign q_valid = v[DEPTH-1];
  assign fill    = fill_r;
  assign full    = (fill_r == FULL_CNT);

`ifdef ENABLE_DELAY_LINE_TAPS_EN
  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign taps[g*WIDTH +: WIDTH] = stage[g];
  end
`endif

endmodule

// File: tb/tb_enable_delay_line.sv
// Randomised scoreboard bench for enable_delay_line: a DEPTH=4 instance and a DEPTH=1/RST_VAL=8'h5A instance share stimulus.
module tb_enable_delay_line;

  localparam logic [7:0] RV1 = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_n, enable, flush, d_valid;
  logic [7:0] d;

  logic [7:0] q4, q1;
  logic       qv4, qv1, full4, full1;
  logic [2:0] fill4;
  logic [0:0] fill1;
`ifdef ENABLE_DELAY_LINE_TAPS_EN
  logic [31:0] taps4;
  logic [7:0]  taps1;
`endif

  int checks = 0;
  int errors = 0;

  // stream scoreboards: valid words in issue order
  logic [7:0] exp4[$];
  logic [7:0] exp1[$];
  // stage-content models, index 0 = newest
  logic [7:0] m4d[$];
  bit         m4v[$];
  logic [7:0] m1d[$];
  bit         m1v[$];

  enable_delay_line #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q4), .q_valid(qv4), .fill(fill4), .full(full4)
`ifdef ENABLE_DELAY_LINE_TAPS_EN
    , .taps(taps4)
`endif
  );

  enable_delay_line #(.WIDTH(8), .DEPTH(1), .RST_VAL(RV1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q1), .q_valid(qv1), .fill(fill1), .full(full1)
`ifdef ENABLE_DELAY_LINE_TAPS_EN
    , .taps(taps1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m4d.delete(); m4v.delete(); m1d.delete(); m1v.delete();
    for (int i = 0; i < 4; i++) begin m4d.push_back(8'h00); m4v.push_back(1'b0); end
    m1d.push_back(RV1); m1v.push_back(1'b0);
  endtask

  task automatic model_shift(input bit vv, input logic [7:0] dd);
    m4d.push_front(dd); m4v.push_front(vv); void'(m4d.pop_back()); void'(m4v.pop_back());
    m1d.push_front(dd); m1v.push_front(vv); void'(m1d.pop_back()); void'(m1v.pop_back());
  endtask

  task automatic check_state(input string tag);
    int c4, c1;
    c4 = 0; c1 = 0;
    foreach (m4v[i]) c4 += int'(m4v[i]);
    foreach (m1v[i]) c1 += int'(m1v[i]);
    chk({tag, " q4"},     q4,    m4d[3]);
    chk({tag, " qv4"},    qv4,   m4v[3]);
    chk({tag, " fill4"},  fill4, c4);
    chk({tag, " full4"},  full4, (c4 == 4));
    chk({tag, " q1"},     q1,    m1d[0]);
    chk({tag, " qv1"},    qv1,   m1v[0]);
    chk({tag, " fill1"},  fill1, c1);
    chk({tag, " full1"},  full1, (c1 == 1));
`ifdef ENABLE_DELAY_LINE_TAPS_EN
    for (int i = 0; i < 4; i++) chk({tag, " taps4"}, taps4[i*8 +: 8], m4d[i]);
    chk({tag, " taps1"}, taps1, m1d[0]);
`endif
  endtask

  // monitor: advance the models with the inputs seen at the edge, then compare
  always @(posedge clk) begin
    automatic bit         r  = rst_n;
    automatic bit         f  = flush;
    automatic bit         e  = enable;
    automatic bit         vv = d_valid;
    automatic logic [7:0] dd = d;
    if (!r || f) model_reset();
    else if (e) model_shift(vv, dd);
    #1;
    check_state("cyc");
    if (r && !f && e) begin
      if (qv4) begin
        if (exp4.size() == 0) chk("sb4 empty", 1, 0);
        else chk("sb4 word", q4, exp4.pop_front());
      end
      if (qv1) begin
        if (exp1.size() == 0) chk("sb1 empty", 1, 0);
        else chk("sb1 word", q1, exp1.pop_front());
      end
    end
  end

  task automatic drive(input bit en, input bit fl, input bit dv, input logic [7:0] dd);
    @(negedge clk);
    enable = en; flush = fl; d_valid = dv; d = dd;
    if (rst_n && fl) begin exp4.delete(); exp1.delete(); end
    else if (rst_n && en && dv) begin exp4.push_back(dd); exp1.push_back(dd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 1'b0; enable = 1'b1; flush = 1'b0; d_valid = 1'b1; d = 8'hAA;
    // reset held while inputs toggle
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, (i % 2) ? 8'h55 : 8'hAA);
    @(negedge clk); rst_n = 1'b1;
    enable = 1'b0; d_valid = 1'b0;
    // latency: 8'h11 emerges on the 4th enabled edge
    drive(1, 0, 1, 8'h11);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 8'h00);
    // stall with two words inside
    drive(1, 0, 1, 8'h11);
    drive(1, 0, 1, 8'h22);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 8'hEE);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 8'h00);
    // fill up, steady stream at full, then drain
    for (int i = 0; i < 8; i++) drive(1, 0, 1, 8'h30 + 8'(i));
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 8'h00);
    // bubble carries its data with valid low
    drive(1, 0, 1, 8'h01);
    drive(1, 0, 0, 8'hFF);
    drive(1, 0, 1, 8'h03);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 8'h00);
    // flush beats enable with fill=3
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 8'h40 + 8'(i));
    drive(1, 1, 1, 8'h55);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 8'h00);
    // asynchronous reset between edges with fill=2
    drive(1, 0, 1, 8'h61);
    drive(1, 0, 1, 8'h62);
    @(negedge clk);
    enable = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp4.delete(); exp1.delete(); model_reset();
    chk("arst q4", q4, 8'h00);
    chk("arst qv4", qv4, 1'b0);
    chk("arst fill4", fill4, 3'd0);
    chk("arst full4", full4, 1'b0);
    chk("arst q1", q1, RV1);
    chk("arst qv1", qv1, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    // randomised traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
            $urandom_range(0, 1) == 1, 8'($urandom));
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 8'h00);
    @(negedge clk);
    chk("sb4 drained", exp4.size(), 0);
    chk("sb1 drained", exp1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
